// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - registered ALU execute stage with one-entry skid buffer
// Optional signed-overflow output is enabled by defining ALU_EX_OVF_EN.
module alu_ex_stage #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_aluctr,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [TAGW-1:0]  out_tag
`ifdef ALU_EX_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_zero, alu_illegal, sub_ovf, lt;

    always_comb begin
        sum         = in_a + in_b;
        diff        = in_a - in_b;
        sub_ovf     = (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & (diff[WIDTH-1] ^ in_a[WIDTH-1]);
        lt          = diff[WIDTH-1] ^ sub_ovf;
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (in_aluctr)
            3'b000:  alu_res = in_a & in_b;
            3'b001:  alu_res = in_a | in_b;
            3'b010:  alu_res = sum;
            3'b110:  alu_res = diff;
            3'b111:  alu_res = {{(WIDTH-1){1'b0}}, lt};
            default: alu_illegal = 1'b1;
        endcase
        alu_zero = (alu_res == '0);
    end

`ifdef ALU_EX_OVF_EN
    logic alu_ovf;
    always_comb begin
        alu_ovf = 1'b0;
        if (in_aluctr == 3'b010)
            alu_ovf = ~(in_a[WIDTH-1] ^ in_b[WIDTH-1]) & (sum[WIDTH-1] ^ in_a[WIDTH-1]);
        else if (in_aluctr == 3'b110)
            alu_ovf = sub_ovf;
    end
`endif

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] out_result_q, skid_result_q;
    logic             out_zero_q, skid_zero_q;
    logic             out_illegal_q, skid_illegal_q;
    logic [TAGW-1:0]  out_tag_q, skid_tag_q;
    logic             in_xfer, out_xfer;
    logic             load_out_new, load_out_skid, load_skid;

    // in_ready is simply the inverted skid flop, so it is registered by construction
    assign in_ready = ~skid_valid_q;
    assign in_xfer  = in_valid & ~skid_valid_q;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        out_valid_d   = out_valid_q;
        skid_valid_d  = skid_valid_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_xfer) begin
            if (skid_valid_q) begin
                load_out_skid = 1'b1;
                skid_valid_d  = 1'b0;
            end else if (in_xfer) begin
                load_out_new = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (out_valid_q) begin
                load_skid    = 1'b1;
                skid_valid_d = 1'b1;
            end else begin
                load_out_new = 1'b1;
                out_valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            skid_valid_q   <= 1'b0;
            out_result_q   <= '0;
            out_zero_q     <= 1'b0;
            out_illegal_q  <= 1'b0;
            out_tag_q      <= '0;
            skid_result_q  <= '0;
            skid_zero_q    <= 1'b0;
            skid_illegal_q <= 1'b0;
            skid_tag_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            if (load_out_new) begin
                out_result_q  <= alu_res;
                out_zero_q    <= alu_zero;
                out_illegal_q <= alu_illegal;
                out_tag_q     <= in_tag;
            end else if (load_out_skid) begin
                out_result_q  <= skid_result_q;
                out_zero_q    <= skid_zero_q;
                out_illegal_q <= skid_illegal_q;
                out_tag_q     <= skid_tag_q;
            end
            if (load_skid) begin
                skid_result_q  <= alu_res;
                skid_zero_q    <= alu_zero;
                skid_illegal_q <= alu_illegal;
                skid_tag_q     <= in_tag;
            end
        end
    end

`ifdef ALU_EX_OVF_EN
    logic out_ovf_q, skid_ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf_q  <= 1'b0;
            skid_ovf_q <= 1'b0;
        end else begin
            if (load_out_new)
                out_ovf_q <= alu_ovf;
            else if (load_out_skid)
                out_ovf_q <= skid_ovf_q;
            if (load_skid)
                skid_ovf_q <= alu_ovf;
        end
    end
    assign out_ovf = out_ovf_q;
`endif

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_zero    = out_zero_q;
    assign out_illegal = out_illegal_q;
    assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb/tb_alu_ex_stage.sv - self-checking bench for alu_ex_stage
module tb_alu_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [2:0]  in_aluctr;
    logic [4:0]  in_tag, out_tag;
    logic        out_zero, out_illegal, out_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ex_stage #(.WIDTH(32), .TAGW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_aluctr(in_aluctr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_illegal(out_illegal), .out_tag(out_tag)
`ifdef ALU_EX_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

`ifndef ALU_EX_OVF_EN
    assign out_ovf = 1'b0;
`endif

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  code;
        logic [4:0]  tag;
        logic [31:0] res;
        logic        zero, ill, ovf;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        zero, ill, ovf;
        logic [4:0]  tag;
    } res_t;

    vec_t vecs[13];
    res_t model_q[$];
    logic m_in_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] code, input logic [4:0] tag);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_aluctr = code;
        in_tag    = tag;
    endtask

    // Reference ALU from arithmetic definitions: 64-bit signed math, overflow = not representable
    function automatic res_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] code, input logic [4:0] tag);
        res_t   r;
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.ill = 1'b0;
        r.ovf = 1'b0;
        r.tag = tag;
        case (code)
            3'd0: r.res = a & b;
            3'd1: r.res = a | b;
            3'd2: begin
                s = sa + sb;
                r.res = s[31:0];
                r.ovf = (s != longint'($signed(s[31:0])));
            end
            3'd6: begin
                s = sa - sb;
                r.res = s[31:0];
                r.ovf = (s != longint'($signed(s[31:0])));
            end
            3'd7: r.res = (sa < sb) ? 32'd1 : 32'd0;
            default: begin
                r.res = 32'd0;
                r.ill = 1'b1;
            end
        endcase
        r.zero = (r.res == 32'd0);
        return r;
    endfunction

    task automatic chk_out(input string name, input res_t e);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_res"}, 64'(out_result), 64'(e.res));
        chk({name, "_zero"}, 64'(out_zero), 64'(e.zero));
        chk({name, "_ill"}, 64'(out_illegal), 64'(e.ill));
        chk({name, "_tag"}, 64'(out_tag), 64'(e.tag));
`ifdef ALU_EX_OVF_EN
        chk({name, "_ovf"}, 64'(out_ovf), 64'(e.ovf));
`endif
    endtask

    // One model-checked cycle; entered and left just after a falling edge
    task automatic rcycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] code, input logic [4:0] tag,
                          input logic ordy, input logic fl);
        logic in_x, out_x;
        chk("rnd_in_ready", 64'(in_ready), 64'(m_in_ready));
        chk("rnd_out_valid", 64'(out_valid), 64'(model_q.size() > 0));
        if (model_q.size() > 0 && out_valid)
            chk_out("rnd", model_q[0]);
        drive(v, a, b, code, tag);
        out_ready = ordy;
        flush     = fl;
        in_x  = v && m_in_ready;
        out_x = (model_q.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (out_x) void'(model_q.pop_front());
            if (in_x) model_q.push_back(ref_alu(a, b, code, tag));
        end
        m_in_ready = (model_q.size() < 2);
        @(negedge clk);
    endtask

    function automatic res_t mk(input logic [31:0] r, input logic z, input logic il,
                                input logic [4:0] t);
        res_t e;
        e.res = r; e.zero = z; e.ill = il; e.tag = t; e.ovf = 1'b0;
        return e;
    endfunction

    initial begin
        vecs[0]  = '{32'd5, 32'd7, 3'b010, 5'd1, 32'd12, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'd3, 32'd3, 3'b110, 5'd2, 32'd0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'hFFFF_FFFF, 32'd1, 3'b111, 5'd3, 32'd1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'd1, 32'hFFFF_FFFF, 3'b111, 5'd4, 32'd0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'd9, 32'd9, 3'b100, 5'd5, 32'd0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h0F, 32'h3C, 3'b000, 5'd6, 32'h0C, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h0F, 32'h3C, 3'b001, 5'd7, 32'h3F, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'd1, 32'd2, 3'b011, 5'd8, 32'd0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, 5'd31, 32'd0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{32'h7FFF_FFFF, 32'd1, 3'b010, 5'd9, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h8000_0000, 32'd1, 3'b110, 5'd10, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{32'hFFFF_FFFF, 32'hF0F0_F0F0, 3'b000, 5'd11, 32'hF0F0_F0F0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 5'd12, 32'd1, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result", 64'(out_result), 64'd0);
        chk("rst_zero", 64'(out_zero), 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_ovf", 64'(out_ovf), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back table vectors, draining every cycle
        for (int i = 0; i < 13; i++) begin
            res_t e;
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].code, vecs[i].tag);
            @(negedge clk);
            drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
            e = mk(vecs[i].res, vecs[i].zero, vecs[i].ill, vecs[i].tag);
            e.ovf = vecs[i].ovf;
            chk_out($sformatf("vec%0d", i), e);
        end
        @(negedge clk);
        chk("table_drained", 64'(out_valid), 64'd0);

        // Backpressure: two ops fill OUT and SKID, third waits upstream
        out_ready = 1'b0;
        drive(1'b1, 32'h0F, 32'h3C, 3'b000, 5'd1);
        @(negedge clk);
        chk("bp_ready_one", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h0F, 32'h3C, 3'b001, 5'd2);
        @(negedge clk);
        chk("bp_ready_full", 64'(in_ready), 64'd0);
        chk_out("bp_full_head", mk(32'h0C, 1'b0, 1'b0, 5'd1));
        drive(1'b1, 32'd10, 32'd20, 3'b010, 5'd3);
        repeat (2) @(negedge clk);
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        chk_out("bp_stable", mk(32'h0C, 1'b0, 1'b0, 5'd1));
        out_ready = 1'b1;
        @(negedge clk);
        chk_out("bp_second", mk(32'h3F, 1'b0, 1'b0, 5'd2));
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
        chk_out("bp_third", mk(32'd30, 1'b0, 1'b0, 5'd3));
        @(negedge clk);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush while FULL with an op presented
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd1, 3'b010, 5'd4);
        @(negedge clk);
        drive(1'b1, 32'd2, 32'd2, 3'b010, 5'd5);
        @(negedge clk);
        chk("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'd3, 32'd3, 3'b010, 5'd6);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("fl_quiet%0d", i), 64'(out_valid), 64'd0);
        end

        // Asynchronous reset while FULL clears both registers at once
        out_ready = 1'b0;
        drive(1'b1, 32'd7, 32'd1, 3'b001, 5'd7);
        @(negedge clk);
        drive(1'b1, 32'd7, 32'd2, 3'b001, 5'd8);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_result", 64'(out_result), 64'd0);
        chk("arst_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_no_ghost", 64'(out_valid), 64'd0);

        // Randomized traffic against the queue model
        m_in_ready = 1'b1;
        model_q.delete();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b;
            case ($urandom_range(0, 3))
                0: begin a = $urandom_range(0, 3); b = $urandom_range(0, 3); end
                1: begin a = 32'h8000_0000 ^ $urandom_range(0, 1); b = $urandom_range(0, 1); end
                2: begin a = 32'h7FFF_FFFF; b = $urandom; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            rcycle(1'($urandom_range(0, 3) != 0), a, b, 3'($urandom_range(0, 7)),
                   5'($urandom), 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 39) == 0));
        end
        rcycle(1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
